tmr_array: RTL and testbench

Multi-channel programmable interval timer for the mips789 peripheral space, generalising the single-channel reload timer. It provides `NCH` independent down-counters of width `W`, all driven by one shared prescaler. Each channel runs in periodic or one-shot mode and has a sticky request flag with a per-channel interrupt enable. A single-cycle write / registered-read register port connects it to the CPU data bus.

---
 rtl/tmr_array.sv | 194 +++++++++++++++++++
 tb/tb_tmr_array.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tmr_array.sv
// Multi-channel programmable interval timer: NCH down-counters sharing one prescaler,
// periodic/one-shot modes, sticky requests. Define TMR_ARRAY_OVR_EN to add overrun flags.
module tmr_array #(
  parameter int unsigned NCH = 2,
  parameter int unsigned W   = 32,
  parameter int unsigned PSW = 8,
  parameter int unsigned AW  = $clog2(NCH) + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [AW-1:0]    addr,
  input  logic [31:0]      din,
  output logic [31:0]      rdata,
  output logic [NCH-1:0]   tmr_req,
  output logic             irq,
  output logic [NCH*W-1:0] cntr_o
);

  localparam int unsigned CW = (AW > 2) ? AW - 2 : 1;

  typedef enum logic [1:0] {RegRld, RegCtl, RegPsc, RegStat} reg_e;

  logic [CW-1:0]  ch;
  logic           ch_ok;
  reg_e           reg_sel;

  logic [NCH-1:0] wr_rld;
  logic [NCH-1:0] wr_ctl;
  logic           wr_psc;
  logic           wr_stat;

  logic [W-1:0]   cntr_q [NCH];
  logic [W-1:0]   cntr_d [NCH];
  logic [W-1:0]   rld_q  [NCH];
  logic [W-1:0]   rld_d  [NCH];
  logic [NCH-1:0] en_q, en_d;
  logic [NCH-1:0] os_q, os_d;
  logic [NCH-1:0] ie_q, ie_d;
  logic [NCH-1:0] req_q, req_d;
  logic [NCH-1:0] ovr_q;
  logic [NCH-1:0] evt;

  logic [PSW-1:0] psc_q, psc_d;
  logic [PSW-1:0] pcnt_q, pcnt_d;
  logic           tick;

  logic [31:0]    stat;
  logic [31:0]    rdata_q, rdata_d;

  // Address decode
  always_comb begin
    ch      = CW'(addr >> 2);
    ch_ok   = 32'(ch) < NCH;
    reg_sel = reg_e'(addr[1:0]);
    wr_psc  = wr && (reg_sel == RegPsc);
    wr_stat = wr && (reg_sel == RegStat);
    wr_rld  = '0;
    wr_ctl  = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_rld[i] = wr && (reg_sel == RegRld) && (ch == CW'(i));
      wr_ctl[i] = wr && (reg_sel == RegCtl) && (ch == CW'(i));
    end
  end

  // Shared prescaler
  assign tick = (pcnt_q == '0);

  always_comb begin
    psc_d  = psc_q;
    pcnt_d = tick ? psc_q : pcnt_q - PSW'(1);
    if (wr_psc) begin
      psc_d  = din[PSW-1:0];
      pcnt_d = din[PSW-1:0];
    end
  end

  // Channel next state; register writes are applied after counting so they take priority
  always_comb begin
    cntr_d = cntr_q;
    rld_d  = rld_q;
    en_d   = en_q;
    os_d   = os_q;
    ie_d   = ie_q;
    req_d  = req_q;
    evt    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (tick && en_q[i]) begin
        if (cntr_q[i] == '0) begin
          // A reload written on the same edge suppresses the event
          evt[i] = !wr_rld[i];
          if (os_q[i]) begin
            en_d[i] = 1'b0;
          end else begin
            cntr_d[i] = rld_q[i];
          end
        end else begin
          cntr_d[i] = cntr_q[i] - W'(1);
        end
      end
      if (wr_rld[i]) begin
        rld_d[i]  = din[W-1:0];
        cntr_d[i] = din[W-1:0];
      end
      if (wr_ctl[i]) begin
        en_d[i] = din[0];
        os_d[i] = din[1];
        ie_d[i] = din[2];
      end
      req_d[i] = (req_q[i] & ~(wr_stat & din[i])) | evt[i];
    end
  end

`ifdef TMR_ARRAY_OVR_EN
  logic [NCH-1:0] ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    for (int i = 0; i < NCH; i++) begin
      ovr_d[i] = (ovr_q[i] & ~(wr_stat & din[16+i])) | (evt[i] & req_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_d;
    end
  end
`else
  assign ovr_q = '0;
`endif

  // Read mux samples pre-write state
  always_comb begin
    stat            = '0;
    stat[NCH-1:0]   = req_q;
    stat[16 +: NCH] = ovr_q;
    rdata_d         = '0;
    unique case (reg_sel)
      RegRld: begin
        if (ch_ok) rdata_d = 32'(cntr_q[ch]);
      end
      RegCtl: begin
        if (ch_ok) begin
          rdata_d = {22'b0, ovr_q[ch], req_q[ch], 5'b0, ie_q[ch], os_q[ch], en_q[ch]};
        end
      end
      RegPsc:  rdata_d = 32'(psc_q);
      RegStat: rdata_d = stat;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cntr_q[i] <= '0;
        rld_q[i]  <= '0;
      end
      en_q    <= '0;
      os_q    <= '0;
      ie_q    <= '0;
      req_q   <= '0;
      psc_q   <= '0;
      pcnt_q  <= '0;
      rdata_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cntr_q[i] <= cntr_d[i];
        rld_q[i]  <= rld_d[i];
      end
      en_q    <= en_d;
      os_q    <= os_d;
      ie_q    <= ie_d;
      req_q   <= req_d;
      psc_q   <= psc_d;
      pcnt_q  <= pcnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    cntr_o = '0;
    for (int i = 0; i < NCH; i++) begin
      cntr_o[i*W +: W] = cntr_q[i];
    end
  end

  assign rdata   = rdata_q;
  assign tmr_req = req_q;
  assign irq     = |(req_q & ie_q);

endmodule

// File: tb/tb_tmr_array.sv
// Directed bench for tmr_array (NCH=2, W=32, PSW=8): vector table plus corner sequences.
module tb_tmr_array;

`ifdef TMR_ARRAY_OVR_EN
  localparam logic [31:0] OVR = 32'd1;
`else
  localparam logic [31:0] OVR = 32'd0;
`endif

  logic        clk;
  logic        rst;
  logic        wr;
  logic [2:0]  addr;
  logic [31:0] din;
  logic [31:0] rdata;
  logic [1:0]  tmr_req;
  logic        irq;
  logic [63:0] cntr_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_req;
    logic        exp_irq;
    logic [31:0] exp_c0;
    logic [31:0] exp_c1;
  } vec_t;

  vec_t vec [19];

  tmr_array #(
    .NCH(2),
    .W  (32),
    .PSW(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr     (wr),
    .addr   (addr),
    .din    (din),
    .rdata  (rdata),
    .tmr_req(tmr_req),
    .irq    (irq),
    .cntr_o (cntr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int n;

  initial begin
    // wr, addr, din, rdata, req, irq, cntr0, cntr1
    vec[0]  = '{1'b1, 3'd0, 32'd3,       32'h0,                 2'b00, 1'b0, 32'd3, 32'd0};
    vec[1]  = '{1'b1, 3'd1, 32'd1,       32'h0,                 2'b00, 1'b0, 32'd3, 32'd0};
    vec[2]  = '{1'b0, 3'd0, 32'd0,       32'h3,                 2'b00, 1'b0, 32'd2, 32'd0};
    vec[3]  = '{1'b0, 3'd0, 32'd0,       32'h2,                 2'b00, 1'b0, 32'd1, 32'd0};
    vec[4]  = '{1'b0, 3'd0, 32'd0,       32'h1,                 2'b00, 1'b0, 32'd0, 32'd0};
    vec[5]  = '{1'b0, 3'd0, 32'd0,       32'h0,                 2'b01, 1'b0, 32'd3, 32'd0};
    vec[6]  = '{1'b0, 3'd0, 32'd0,       32'h3,                 2'b01, 1'b0, 32'd2, 32'd0};
    vec[7]  = '{1'b0, 3'd3, 32'd0,       32'h1,                 2'b01, 1'b0, 32'd1, 32'd0};
    vec[8]  = '{1'b1, 3'd1, 32'd5,       32'h101,               2'b01, 1'b1, 32'd0, 32'd0};
    vec[9]  = '{1'b1, 3'd3, 32'd1,       32'h1,                 2'b01, 1'b1, 32'd3, 32'd0};
    vec[10] = '{1'b1, 3'd3, 32'd1,       32'h1 | (OVR << 16),   2'b00, 1'b0, 32'd2, 32'd0};
    vec[11] = '{1'b0, 3'd1, 32'd0,       32'h5 | (OVR << 9),    2'b00, 1'b0, 32'd1, 32'd0};
    vec[12] = '{1'b0, 3'd0, 32'd0,       32'h1,                 2'b00, 1'b0, 32'd0, 32'd0};
    vec[13] = '{1'b1, 3'd0, 32'd5,       32'h0,                 2'b00, 1'b0, 32'd5, 32'd0};
    vec[14] = '{1'b1, 3'd3, 32'h1_0000,  OVR << 16,             2'b00, 1'b0, 32'd4, 32'd0};
    vec[15] = '{1'b0, 3'd3, 32'd0,       32'h0,                 2'b00, 1'b0, 32'd3, 32'd0};
    vec[16] = '{1'b1, 3'd1, 32'd0,       32'h5,                 2'b00, 1'b0, 32'd2, 32'd0};
    vec[17] = '{1'b0, 3'd2, 32'd0,       32'h0,                 2'b00, 1'b0, 32'd2, 32'd0};
    vec[18] = '{1'b0, 3'd0, 32'd0,       32'h2,                 2'b00, 1'b0, 32'd2, 32'd0};

    rst  = 1'b1;
    wr   = 1'b0;
    addr = '0;
    din  = '0;
    step();
    step();
    chk("reset rdata", rdata, 32'h0);
    chk("reset tmr_req", 32'(tmr_req), 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    chk("reset cntr_o lo", cntr_o[31:0], 32'h0);
    rst = 1'b0;

    // Periodic counting, gating, collisions, overrun
    for (int i = 0; i < 19; i++) begin
      wr   = vec[i].wr;
      addr = vec[i].addr;
      din  = vec[i].din;
      step();
      chk($sformatf("v%0d rdata", i), rdata, vec[i].exp_rdata);
      chk($sformatf("v%0d tmr_req", i), 32'(tmr_req), 32'(vec[i].exp_req));
      chk($sformatf("v%0d irq", i), 32'(irq), 32'(vec[i].exp_irq));
      chk($sformatf("v%0d cntr0", i), cntr_o[31:0], vec[i].exp_c0);
      chk($sformatf("v%0d cntr1", i), cntr_o[63:32], vec[i].exp_c1);
    end

    // Prescale 2 + one-shot on ch1
    wr = 1'b1; addr = 3'd6; din = 32'd2; step();
    addr = 3'd4; din = 32'd1; step();
    addr = 3'd5; din = 32'd3; step();
    wr = 1'b0; addr = 3'd5; din = '0;
    n = 0;
    while (!tmr_req[1] && n < 10) begin
      step();
      n++;
    end
    chk("oneshot latency", 32'(n), 32'd4);
    chk("oneshot ctl pre-event", rdata, 32'h003);
    step();
    chk("oneshot ctl en cleared", rdata, 32'h102);
    repeat (9) step();
    chk("oneshot cntr1 holds 0", cntr_o[63:32], 32'd0);
    chk("ch0 disabled holds", cntr_o[31:0], 32'd2);
    addr = 3'd3;
    step();
    chk("oneshot single event stat", rdata, 32'h2);

    // Interrupt gating on ch1
    chk("irq gated by ie", 32'(irq), 32'd0);
    wr = 1'b1; addr = 3'd5; din = 32'd4; step();
    chk("irq after ie set", 32'(irq), 32'd1);
    addr = 3'd3; din = 32'd2; step();
    wr = 1'b0;
    chk("req1 cleared", 32'(tmr_req), 32'd0);
    chk("irq cleared", 32'(irq), 32'd0);

    // Reset mid-count with a pending request
    wr = 1'b1; addr = 3'd2; din = 32'd0; step();
    addr = 3'd0; din = 32'd2; step();
    addr = 3'd1; din = 32'd5; step();
    wr = 1'b0; addr = 3'd0; din = '0;
    repeat (3) step();
    chk("pre-reset cntr0", cntr_o[31:0], 32'd2);
    chk("pre-reset req", 32'(tmr_req), 32'd1);
    chk("pre-reset irq", 32'(irq), 32'd1);
    rst = 1'b1;
    step();
    chk("mid reset rdata", rdata, 32'h0);
    chk("mid reset tmr_req", 32'(tmr_req), 32'd0);
    chk("mid reset irq", 32'(irq), 32'd0);
    chk("mid reset cntr0", cntr_o[31:0], 32'd0);
    rst  = 1'b0;
    addr = 3'd1;
    repeat (3) step();
    chk("post reset cntr0", cntr_o[31:0], 32'd0);
    chk("post reset req", 32'(tmr_req), 32'd0);
    chk("post reset ctl", rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
